// File: rtl/scale_down_nx_2ppc.sv
// scale_down_nx_2ppc
// Purpose: 2-pixel-per-clock RGB downscaler for the camera path. It keeps one
// input row in SCALE and turns every SCALE input pixels into one output pixel.
// Each output pixel is either the first pixel of its group (MODE=0) or the
// round-half-up average of the group (MODE=1). Two output pixels are packed
// into one output beat, and the output beat coordinates are produced with it.
// The position of a pixel inside a word is taken only from in_x. Gaps in
// in_valid and lines that end early therefore do not upset the phase.
// Ports:
//   clk, rst_n          pixel clock, synchronous active-low reset
//   in_x, in_y          input beat index within the line, input line index
//   in_red/green/blue   two pixels per beat; the low half is the even pixel
//   in_valid            beat qualifier; it may drop on any cycle
//   out_x, out_y        output beat index within the line, output line index
//   out_red/green/blue  two output pixels; the low half is the earlier pixel
//   out_valid           one-cycle strobe for each finished output beat
module scale_down_nx_2ppc #(
  parameter int P_DEPTH        = 8,
  parameter int IN_FRAME_WIDTH = 1080,
  parameter int SCALE          = 2,
  parameter int MODE           = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [10:0]          in_x,
  input  logic [10:0]          in_y,
  input  logic [2*P_DEPTH-1:0] in_red,
  input  logic [2*P_DEPTH-1:0] in_green,
  input  logic [2*P_DEPTH-1:0] in_blue,
  input  logic                 in_valid,
  output logic [10:0]          out_x,
  output logic [10:0]          out_y,
  output logic [2*P_DEPTH-1:0] out_red,
  output logic [2*P_DEPTH-1:0] out_green,
  output logic [2*P_DEPTH-1:0] out_blue,
  output logic                 out_valid
);

  localparam int SH = (SCALE == 4) ? 2 : 1;   // log2(SCALE)
  localparam int AW = P_DEPTH + 2;            // large enough for a four-pixel sum
  localparam int PW = 2 * P_DEPTH;

  generate
    if (SCALE != 2 && SCALE != 4) begin : g_bad_scale
      $error("scale_down_nx_2ppc: SCALE must be 2 or 4");
    end
    if ((IN_FRAME_WIDTH % (2 * SCALE)) != 0) begin : g_bad_width
      $error("scale_down_nx_2ppc: IN_FRAME_WIDTH must be a multiple of 2*SCALE");
    end
  endgenerate

  // Adds the two pixels of one beat.
  function automatic logic [AW-1:0] pair_sum(input logic [PW-1:0] beat);
    pair_sum = {2'b00, beat[P_DEPTH-1:0]} + {2'b00, beat[PW-1:P_DEPTH]};
  endfunction

  // Averages the two pixels of one beat, rounding half up.
  function automatic logic [P_DEPTH-1:0] avg2(input logic [PW-1:0] beat);
    logic [AW-1:0] t;
    t    = pair_sum(beat) + AW'(1);
    avg2 = t[P_DEPTH:1];
  endfunction

  // Averages a stored pixel pair and the current beat, rounding half up.
  function automatic logic [P_DEPTH-1:0] avg4(input logic [AW-1:0] acc,
                                              input logic [PW-1:0] beat);
    logic [AW-1:0] t;
    t    = acc + pair_sum(beat) + AW'(2);
    avg4 = t[P_DEPTH+1:2];
  endfunction

  logic [PW-1:0]      beat_s [3];
  logic [P_DEPTH-1:0] pix_s  [3];
  logic [P_DEPTH-1:0] lsb_r  [3];
  logic               lsb_vld_r;
  logic               keep_s;
  logic               slot_s;
  logic               pix_done_s;
  logic               word_done_s;

  assign beat_s[0] = in_red;
  assign beat_s[1] = in_green;
  assign beat_s[2] = in_blue;

  // Accept a beat only on kept rows. slot_s selects the half of the output word.
  always_comb begin
    keep_s      = 1'b0;
    slot_s      = in_x[SH-1];
    if (in_valid && (in_y[SH-1:0] == {SH{1'b0}})) begin
      keep_s = 1'b1;
    end else begin
      keep_s = 1'b0;
    end
    word_done_s = pix_done_s && slot_s && lsb_vld_r;
  end

  generate
    if (SCALE == 4) begin : g_s4
      logic even_vld_r;

      // Record whether the even beat of the current pair has been seen.
      // The odd beat finishes the pixel only when it has.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          even_vld_r <= 1'b0;
        end else if (keep_s) begin
          even_vld_r <= ~in_x[0];
        end else begin
          even_vld_r <= even_vld_r;
        end
      end

      assign pix_done_s = keep_s && in_x[0] && even_vld_r;

      if (MODE == 1) begin : g_avg
        logic [AW-1:0] acc_r [3];

        // Store the sum of the even beat's two pixels until the odd beat arrives.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int c = 0; c < 3; c++) acc_r[c] <= {AW{1'b0}};
          end else if (keep_s && !in_x[0]) begin
            for (int c = 0; c < 3; c++) acc_r[c] <= pair_sum(beat_s[c]);
          end else begin
            for (int c = 0; c < 3; c++) acc_r[c] <= acc_r[c];
          end
        end

        // Average of the four pixels in the pair.
        always_comb begin
          for (int c = 0; c < 3; c++) pix_s[c] = {P_DEPTH{1'b0}};
          for (int c = 0; c < 3; c++) pix_s[c] = avg4(acc_r[c], beat_s[c]);
        end
      end else begin : g_nn
        logic [P_DEPTH-1:0] nn_r [3];

        // Store the low pixel of the even beat; it is the pixel sent out.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            for (int c = 0; c < 3; c++) nn_r[c] <= {P_DEPTH{1'b0}};
          end else if (keep_s && !in_x[0]) begin
            for (int c = 0; c < 3; c++) nn_r[c] <= beat_s[c][P_DEPTH-1:0];
          end else begin
            for (int c = 0; c < 3; c++) nn_r[c] <= nn_r[c];
          end
        end

        // Output the stored pixel.
        always_comb begin
          for (int c = 0; c < 3; c++) pix_s[c] = {P_DEPTH{1'b0}};
          for (int c = 0; c < 3; c++) pix_s[c] = nn_r[c];
        end
      end
    end else begin : g_s2
      assign pix_done_s = keep_s;

      // Each beat becomes one pixel: its low pixel, or the average of its two pixels.
      always_comb begin
        for (int c = 0; c < 3; c++) pix_s[c] = {P_DEPTH{1'b0}};
        for (int c = 0; c < 3; c++) begin
          if (MODE == 1) begin
            pix_s[c] = avg2(beat_s[c]);
          end else begin
            pix_s[c] = beat_s[c][P_DEPTH-1:0];
          end
        end
      end
    end

    if (MODE == 0) begin : g_nn_sink
      // Nearest neighbour never uses the odd pixel of a beat.
      logic unused_hi_s;
      assign unused_hi_s = ^{in_red[PW-1:P_DEPTH], in_green[PW-1:P_DEPTH],
                             in_blue[PW-1:P_DEPTH]};
    end
  endgenerate

  // Hold the slot-0 pixel until slot 1 completes the word. A beat with
  // in_x==0 clears any half-finished word left by a line that ended early.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lsb_vld_r <= 1'b0;
      for (int c = 0; c < 3; c++) lsb_r[c] <= {P_DEPTH{1'b0}};
    end else if (pix_done_s && !slot_s) begin
      lsb_vld_r <= 1'b1;
      for (int c = 0; c < 3; c++) lsb_r[c] <= pix_s[c];
    end else if (word_done_s || (keep_s && (in_x == 11'd0))) begin
      lsb_vld_r <= 1'b0;
      for (int c = 0; c < 3; c++) lsb_r[c] <= lsb_r[c];
    end else begin
      lsb_vld_r <= lsb_vld_r;
      for (int c = 0; c < 3; c++) lsb_r[c] <= lsb_r[c];
    end
  end

  // Output register: pulse out_valid for a finished word; otherwise hold the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x     <= 11'd0;
      out_y     <= 11'd0;
      out_red   <= {PW{1'b0}};
      out_green <= {PW{1'b0}};
      out_blue  <= {PW{1'b0}};
    end else if (word_done_s) begin
      out_valid <= 1'b1;
      out_x     <= in_x >> SH;
      out_y     <= in_y >> SH;
      out_red   <= {pix_s[0], lsb_r[0]};
      out_green <= {pix_s[1], lsb_r[1]};
      out_blue  <= {pix_s[2], lsb_r[2]};
    end else begin
      out_valid <= 1'b0;
      out_x     <= out_x;
      out_y     <= out_y;
      out_red   <= out_red;
      out_green <= out_green;
      out_blue  <= out_blue;
    end
  end

endmodule

// File: tb/tb_scale_down_nx_2ppc.sv
// Testbench for scale_down_nx_2ppc. Four copies of the design run side by
// side on the same stimulus: SCALE 2 and 4, each with MODE 0 and 1.
// A reference model builds each expected output word from the pixels of the
// row and records the cycle on which its strobe should appear.
module tb_scale_down_nx_2ppc;

  localparam int PD = 8;
  localparam int FW = 16;
  localparam int NB = FW / 2;

  typedef struct packed {
    logic [31:0] cyc;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] in_x, in_y;
  logic [15:0] in_red, in_green, in_blue;
  logic        in_valid;

  logic        ov  [4];
  logic [10:0] ox  [4];
  logic [10:0] oy  [4];
  logic [15:0] orr [4];
  logic [15:0] og  [4];
  logic [15:0] ob  [4];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  rec_t exp_q [4][$];
  rec_t act_q [4][$];

  // Model row memory, one per configuration.
  logic [7:0] mr [4][16];
  logic [7:0] mg [4][16];
  logic [7:0] mb [4][16];
  bit         mp [4][16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scale_down_nx_2ppc #(.P_DEPTH(PD), .IN_FRAME_WIDTH(FW), .SCALE(2), .MODE(0)) u_s2_nn (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_red(in_red),
    .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid), .out_x(ox[0]),
    .out_y(oy[0]), .out_red(orr[0]), .out_green(og[0]), .out_blue(ob[0]), .out_valid(ov[0]));
  scale_down_nx_2ppc #(.P_DEPTH(PD), .IN_FRAME_WIDTH(FW), .SCALE(2), .MODE(1)) u_s2_avg (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_red(in_red),
    .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid), .out_x(ox[1]),
    .out_y(oy[1]), .out_red(orr[1]), .out_green(og[1]), .out_blue(ob[1]), .out_valid(ov[1]));
  scale_down_nx_2ppc #(.P_DEPTH(PD), .IN_FRAME_WIDTH(FW), .SCALE(4), .MODE(0)) u_s4_nn (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_red(in_red),
    .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid), .out_x(ox[2]),
    .out_y(oy[2]), .out_red(orr[2]), .out_green(og[2]), .out_blue(ob[2]), .out_valid(ov[2]));
  scale_down_nx_2ppc #(.P_DEPTH(PD), .IN_FRAME_WIDTH(FW), .SCALE(4), .MODE(1)) u_s4_avg (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_red(in_red),
    .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid), .out_x(ox[3]),
    .out_y(oy[3]), .out_red(orr[3]), .out_green(og[3]), .out_blue(ob[3]), .out_valid(ov[3]));

  // Record every output strobe together with its cycle number.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (ov[c] === 1'b1)
        act_q[c].push_back(rec_t'({32'(cyc), ox[c], oy[c], orr[c], og[c], ob[c]}));
    end
  end

  // One output pixel from the group of s row pixels that starts at 'start'.
  function automatic logic [7:0] grp_val(int c, int col, int start, int s, bit avg);
    int sum;
    logic [7:0] v;
    sum = 0;
    for (int i = 0; i < s; i++) begin
      case (col)
        0: v = mr[c][start+i];
        1: v = mg[c][start+i];
        default: v = mb[c][start+i];
      endcase
      if (i == 0 && !avg) return v;
      sum += int'(v);
    end
    return 8'((sum + s / 2) / s);
  endfunction

  // Update the model with one accepted beat. Word k is built from row pixels
  // 2*S*k .. 2*S*k+2*S-1. It is produced only when all of those pixels have
  // arrived since the row started or since the last reset.
  function automatic void model_beat(int x, int y, logic [15:0] r, logic [15:0] g,
                                     logic [15:0] b, int ecyc);
    for (int c = 0; c < 4; c++) begin
      int s, base;
      bit avg, ok;
      rec_t e;
      s   = (c < 2) ? 2 : 4;
      avg = (c % 2 == 1);
      if (y % s != 0) continue;
      if (x == 0) for (int i = 0; i < 16; i++) mp[c][i] = 1'b0;
      mr[c][2*x] = r[7:0];  mr[c][2*x+1] = r[15:8];
      mg[c][2*x] = g[7:0];  mg[c][2*x+1] = g[15:8];
      mb[c][2*x] = b[7:0];  mb[c][2*x+1] = b[15:8];
      mp[c][2*x] = 1'b1;    mp[c][2*x+1] = 1'b1;
      if (x % s == s - 1) begin
        base = (x / s) * 2 * s;
        ok   = 1'b1;
        for (int i = 0; i < 2 * s; i++) if (!mp[c][base+i]) ok = 1'b0;
        if (ok) begin
          e.cyc = 32'(ecyc);
          e.x   = 11'(x / s);
          e.y   = 11'(y / s);
          e.r   = {grp_val(c, 0, base + s, s, avg), grp_val(c, 0, base, s, avg)};
          e.g   = {grp_val(c, 1, base + s, s, avg), grp_val(c, 1, base, s, avg)};
          e.b   = {grp_val(c, 2, base + s, s, avg), grp_val(c, 2, base, s, avg)};
          exp_q[c].push_back(e);
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) for (int i = 0; i < 16; i++) mp[c][i] = 1'b0;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_x     = 11'($urandom);
      in_red   = 16'($urandom);
    end
  endtask

  // Send beat x of row y after 'gap' idle cycles.
  // pat 0: ramp (red = index, green = 0xFF - index, blue = y); 1: random; 2: all 0xFF.
  task automatic drive_beat(int x, int y, int pat, int gap);
    logic [15:0] r, g, b;
    idle(gap);
    case (pat)
      0: begin
        r = {8'(2*x+1), 8'(2*x)};
        g = {8'(255-(2*x+1)), 8'(255-2*x)};
        b = {8'(y), 8'(y)};
      end
      1: begin
        r = 16'($urandom); g = 16'($urandom); b = 16'($urandom);
      end
      default: begin
        r = 16'hFFFF; g = 16'hFFFF; b = 16'hFFFF;
      end
    endcase
    @(negedge clk);
    in_valid = 1'b1;
    in_x = 11'(x); in_y = 11'(y);
    in_red = r; in_green = g; in_blue = b;
    if (rst_n === 1'b1) model_beat(x, y, r, g, b, cyc + 1);
  endtask

  task automatic send_row(int y, int nbeats, int pat, int maxgap);
    for (int x = 0; x < nbeats; x++)
      drive_beat(x, y, pat, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; in_x = 11'd1; in_y = 11'd0;
    in_red = 16'h1234; in_green = 16'h5678; in_blue = 16'h9ABC;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({ov[c], ox[c], oy[c], orr[c], og[c], ob[c]} !== 71'd0) begin
        n_errors++;
        $display("FAIL reset cfg%0d: got v=%b x=%0d y=%0d r=%h g=%h b=%h, expected all zero",
                 c, ov[c], ox[c], oy[c], orr[c], og[c], ob[c]);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp_rows();
    int nexp [4] = '{12, 12, 4, 4};
    for (int y = 0; y < 5; y++) send_row(y, NB, 0, 0);
    idle(3);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != nexp[c]) begin
        n_errors++;
        $display("FAIL ramp_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), nexp[c]);
      end
    end
    if (act_q[0].size() == 12 && act_q[1].size() == 12 && act_q[2].size() == 4 && act_q[3].size() == 4) begin
      n_checks++;
      if (act_q[0][1].r !== 16'h0604 || act_q[0][3].x !== 11'd3 || act_q[0][4].y !== 11'd1) begin
        n_errors++;
        $display("FAIL ramp_s2_nn: got r=%h x=%0d y=%0d expected 0604 3 1",
                 act_q[0][1].r, act_q[0][3].x, act_q[0][4].y);
      end
      n_checks++;
      if (act_q[1][0].r !== 16'h0301 || act_q[1][0].g !== 16'hFDFF) begin
        n_errors++;
        $display("FAIL ramp_s2_avg: got r=%h g=%h expected 0301 FDFF", act_q[1][0].r, act_q[1][0].g);
      end
      n_checks++;
      if (act_q[2][1].r !== 16'h0C08 || act_q[3][1].r !== 16'h0E0A || act_q[3][2].y !== 11'd1) begin
        n_errors++;
        $display("FAIL ramp_s4: got nn=%h avg=%h y=%0d expected 0C08 0E0A 1",
                 act_q[2][1].r, act_q[3][1].r, act_q[3][2].y);
      end
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != exp_q[c].size()) begin
        n_errors++;
        $display("FAIL ramp_model_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), exp_q[c].size());
      end
      while (act_q[c].size() > 0 && exp_q[c].size() > 0) begin
        rec_t a, e;
        a = act_q[c].pop_front(); e = exp_q[c].pop_front();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL ramp_word cfg%0d: got cyc=%0d x=%0d y=%0d r=%h g=%h b=%h expected cyc=%0d x=%0d y=%0d r=%h g=%h b=%h",
                   c, a.cyc, a.x, a.y, a.r, a.g, a.b, e.cyc, e.x, e.y, e.r, e.g, e.b);
        end
      end
      act_q[c].delete(); exp_q[c].delete();
    end
  endtask

  task automatic test_all_ff();
    send_row(0, NB, 2, 0);
    for (int y = 1; y < 4; y++) send_row(y, NB, 1, 0);
    idle(3);
    n_checks++;
    if (act_q[3].size() < 1 || act_q[1].size() < 1) begin
      n_errors++;
      $display("FAIL all_ff_present: got sizes %0d %0d expected nonzero", act_q[3].size(), act_q[1].size());
    end else if (act_q[3][0].r !== 16'hFFFF || act_q[1][0].g !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL all_ff: got s4=%h s2=%h expected FFFF FFFF", act_q[3][0].r, act_q[1][0].g);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != exp_q[c].size()) begin
        n_errors++;
        $display("FAIL all_ff_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), exp_q[c].size());
      end
      while (act_q[c].size() > 0 && exp_q[c].size() > 0) begin
        rec_t a, e;
        a = act_q[c].pop_front(); e = exp_q[c].pop_front();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL all_ff_word cfg%0d: got cyc=%0d x=%0d y=%0d r=%h g=%h b=%h expected cyc=%0d x=%0d y=%0d r=%h g=%h b=%h",
                   c, a.cyc, a.x, a.y, a.r, a.g, a.b, e.cyc, e.x, e.y, e.r, e.g, e.b);
        end
      end
      act_q[c].delete(); exp_q[c].delete();
    end
  endtask

  task automatic test_gaps_random();
    for (int y = 0; y < 8; y++) send_row(y, NB, 1, 5);
    idle(3);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != exp_q[c].size()) begin
        n_errors++;
        $display("FAIL gaps_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), exp_q[c].size());
      end
      while (act_q[c].size() > 0 && exp_q[c].size() > 0) begin
        rec_t a, e;
        a = act_q[c].pop_front(); e = exp_q[c].pop_front();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL gaps_word cfg%0d: got cyc=%0d x=%0d y=%0d r=%h g=%h b=%h expected cyc=%0d x=%0d y=%0d r=%h g=%h b=%h",
                   c, a.cyc, a.x, a.y, a.r, a.g, a.b, e.cyc, e.x, e.y, e.r, e.g, e.b);
        end
      end
      act_q[c].delete(); exp_q[c].delete();
    end
  endtask

  task automatic test_truncate();
    int nexp [4] = '{12, 12, 3, 3};
    send_row(0, 3, 0, 0);
    send_row(1, NB, 1, 0);
    send_row(2, NB, 0, 1);
    send_row(4, 7, 0, 0);
    send_row(8, NB, 1, 2);
    idle(3);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != nexp[c]) begin
        n_errors++;
        $display("FAIL trunc_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), nexp[c]);
      end
    end
    n_checks++;
    if (act_q[0].size() < 2) begin
      n_errors++;
      $display("FAIL trunc_restart: got %0d words expected at least 2", act_q[0].size());
    end else if (act_q[0][1].r !== 16'h0200 || act_q[0][1].y !== 11'd1 || act_q[0][1].x !== 11'd0) begin
      n_errors++;
      $display("FAIL trunc_restart: got r=%h x=%0d y=%0d expected 0200 0 1",
               act_q[0][1].r, act_q[0][1].x, act_q[0][1].y);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != exp_q[c].size()) begin
        n_errors++;
        $display("FAIL trunc_model_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), exp_q[c].size());
      end
      while (act_q[c].size() > 0 && exp_q[c].size() > 0) begin
        rec_t a, e;
        a = act_q[c].pop_front(); e = exp_q[c].pop_front();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL trunc_word cfg%0d: got cyc=%0d x=%0d y=%0d r=%h g=%h b=%h expected cyc=%0d x=%0d y=%0d r=%h g=%h b=%h",
                   c, a.cyc, a.x, a.y, a.r, a.g, a.b, e.cyc, e.x, e.y, e.r, e.g, e.b);
        end
      end
      act_q[c].delete(); exp_q[c].delete();
    end
  endtask

  task automatic test_reset_midline();
    int nexp [4] = '{5, 5, 2, 2};
    send_row(0, 3, 0, 0);
    // Present beat x=3 while reset is held for two cycles.
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1; in_x = 11'd3; in_y = 11'd0;
    in_red = 16'h0706; in_green = 16'hF8F9; in_blue = 16'h0000;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({ov[c], ox[c], oy[c], orr[c], og[c], ob[c]} !== 71'd0) begin
        n_errors++;
        $display("FAIL midreset cfg%0d: got v=%b x=%0d y=%0d r=%h g=%h b=%h, expected all zero",
                 c, ov[c], ox[c], oy[c], orr[c], og[c], ob[c]);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    send_row(4, NB, 0, 0);
    idle(3);
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (act_q[c].size() != nexp[c]) begin
        n_errors++;
        $display("FAIL midreset_count cfg%0d: got %0d expected %0d", c, act_q[c].size(), nexp[c]);
      end
      while (act_q[c].size() > 0 && exp_q[c].size() > 0) begin
        rec_t a, e;
        a = act_q[c].pop_front(); e = exp_q[c].pop_front();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL midreset_word cfg%0d: got cyc=%0d x=%0d y=%0d r=%h g=%h b=%h expected cyc=%0d x=%0d y=%0d r=%h g=%h b=%h",
                   c, a.cyc, a.x, a.y, a.r, a.g, a.b, e.cyc, e.x, e.y, e.r, e.g, e.b);
        end
      end
      act_q[c].delete(); exp_q[c].delete();
    end
  endtask

  initial begin
    test_reset();
    test_ramp_rows();
    test_all_ff();
    test_gaps_random();
    test_truncate();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
